// File: rtl/vc_fifo.sv
// vc_fifo - per-lane virtual-channel FIFO feeding one router input port.
//
// The link side writes words on i_wr_data; any non-zero word is a push and
// the all-zero word means idle. The arbiter pops one word per cycle with
// i_pop. Read data is registered and forced to zero whenever no word is
// delivered, so downstream logic can treat zero as "nothing here".
// Bits [9:8] of the default 10-bit word are the destination field; the FIFO
// carries them untouched.
//
// Ports:
//   i_clk            single clock, rising edge
//   i_reset          synchronous active-high reset
//   i_wr_data        write word (non-zero = push request)
//   i_pop            pop request from the arbiter
//   i_umbral_alto    almost-full threshold  (o_almost_full  = count >= it)
//   i_umbral_bajo    almost-empty threshold (o_almost_empty = count <= it)
//   o_rd_data        registered read word, zero when not valid
//   o_rd_valid       registered, one cycle per delivered word
//   o_full/o_empty   count == DEPTH / count == 0
//   o_almost_full/o_almost_empty  threshold decodes of the count register
//   o_error          registered overflow/underflow indication
//
// Build option:
//   VC_FIFO_ERR_STICKY_EN  defined   -> o_error is sticky until reset
//                          undefined -> o_error pulses one cycle per event

module vc_fifo #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_pop,
   input  logic [ADDR_W:0]   i_umbral_alto,
   input  logic [ADDR_W:0]   i_umbral_bajo,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_almost_full,
   output logic              o_almost_empty,
   output logic              o_error
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = DEPTH;
   localparam logic [ADDR_W:0] CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_error;

   logic w_full;
   logic w_empty;
   logic w_push_req;
   logic w_push_acc;
   logic w_pop_acc;
   logic w_overflow;
   logic w_underflow;

   assign w_full     = (r_count == CNT_MAX);
   assign w_empty    = (r_count == '0);
   assign w_push_req = |i_wr_data;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign w_push_acc = w_push_req && (!w_full || i_pop);
   // No fall-through: a pop on empty is rejected even if a push arrives.
   assign w_pop_acc  = i_pop && !w_empty;
   assign w_overflow  = w_push_req && w_full && !i_pop;
   assign w_underflow = i_pop && w_empty;

   // Storage is not cleared by reset; reset only makes it unreachable.
   always_ff @(posedge i_clk) begin
      if (!i_reset && w_push_acc) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop_acc) begin
            r_rd_data  <= r_mem[r_rd_ptr];
            r_rd_valid <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
         end else begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end
         case ({w_push_acc, w_pop_acc})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_error <= 1'b0;
      end else begin
`ifdef VC_FIFO_ERR_STICKY_EN
         if (w_overflow || w_underflow) begin
            r_error <= 1'b1;
         end
`else
         r_error <= w_overflow || w_underflow;
`endif
      end
   end

   assign o_rd_data      = r_rd_data;
   assign o_rd_valid     = r_rd_valid;
   assign o_error        = r_error;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= i_umbral_alto);
   assign o_almost_empty = (r_count <= i_umbral_bajo);

endmodule
